seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller
// Shadow/active digit registers; the active copy only changes at a frame boundary.
module seg7_scan_ctrl #(
   parameter int W_DIGIT      = 8,
   parameter int DWELL_CYCLES = 5000,
   parameter int BLANK_CYCLES = 100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [2:0]         wr_idx,
   input  logic [4:0]         wr_char,
   input  logic               wr_dp,
   input  logic               commit,
   input  logic [W_DIGIT-1:0] digit_en,
   output logic [7:0]         abcdefgh,
   output logic [W_DIGIT-1:0] digit,
   output logic               frame_done
);

   localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DWELL_LOAD  = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LOAD  = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);
   localparam logic [2:0]    PTR_LAST    = 3'(W_DIGIT - 1);
   localparam logic [5:0]    BLANK_GLYPH = 6'h1F;

   typedef enum logic {S_BLANK, S_ON} state_t;

   state_t             state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [2:0]         ptr, ptr_n;
   logic               enter_on;
   logic               wrap;
   logic               copy;
   logic               pending;
   logic               wr_fire;
   logic [5:0]         shadow   [W_DIGIT];
   logic [5:0]         active   [W_DIGIT];
   logic [5:0]         active_n [W_DIGIT];
   logic [5:0]         glyph_n;
   logic [W_DIGIT-1:0] onehot_n;
   logic [W_DIGIT-1:0] digit_d;
   logic [7:0]         seg_d;

   // glyph = {dp, char}
   function automatic logic [7:0] encode(input logic [4:0] ch, input logic dp);
      logic [7:0] seg;
      case (ch)
         5'd0:    seg = 8'hFC;
         5'd1:    seg = 8'h60;
         5'd2:    seg = 8'hDA;
         5'd3:    seg = 8'hF2;
         5'd4:    seg = 8'h66;
         5'd5:    seg = 8'hB6;
         5'd6:    seg = 8'hBE;
         5'd7:    seg = 8'hE0;
         5'd8:    seg = 8'hFE;
         5'd9:    seg = 8'hF6;
         5'd10:   seg = 8'hEE;
         5'd11:   seg = 8'h3E;
         5'd12:   seg = 8'h9C;
         5'd13:   seg = 8'h7A;
         5'd14:   seg = 8'h9E;
         5'd15:   seg = 8'h8E;
         5'd16:   seg = 8'hB6;
         5'd17:   seg = 8'h1C;
         5'd18:   seg = 8'h02;
         default: seg = 8'h00;
      endcase
      return {seg[7:1], seg[0] | dp};
   endfunction

   assign wrap    = (state == S_ON) && (cnt == '0) && (ptr == PTR_LAST);
   assign copy    = wrap && pending;
   assign wr_fire = wr_valid && wr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_BLANK;
         cnt   <= BLANK_LOAD;
         ptr   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ptr   <= ptr_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt - 1'b1;
      ptr_n    = ptr;
      enter_on = 1'b0;
      if (cnt == '0) begin
         case (state)
            S_BLANK: begin
               state_n  = S_ON;
               cnt_n    = DWELL_LOAD;
               enter_on = 1'b1;
            end
            default: begin
               ptr_n = (ptr == PTR_LAST) ? 3'd0 : ptr + 3'd1;
               if (BLANK_CYCLES == 0) begin
                  cnt_n    = DWELL_LOAD;
                  enter_on = 1'b1;
               end else begin
                  state_n = S_BLANK;
                  cnt_n   = BLANK_LOAD;
               end
            end
         endcase
      end
   end

   // Slot outputs are captured once on entry to ON so digit_en is sampled per slot.
   always_comb begin
      onehot_n = '0;
      glyph_n  = '0;
      for (int i = 0; i < W_DIGIT; i++) begin
         active_n[i] = copy ? shadow[i] : active[i];
         if (ptr_n == 3'(i)) begin
            onehot_n[i] = 1'b1;
            glyph_n     = active_n[i];
         end
      end
      digit_d = digit;
      seg_d   = abcdefgh;
      if (state_n == S_BLANK) begin
         digit_d = '0;
         seg_d   = '0;
      end else if (enter_on) begin
         digit_d = digit_en & onehot_n;
         seg_d   = encode(glyph_n[4:0], glyph_n[5]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= 1'b0;
         wr_ready   <= 1'b1;
         digit      <= '0;
         abcdefgh   <= '0;
         frame_done <= 1'b0;
         for (int i = 0; i < W_DIGIT; i++) begin
            shadow[i] <= BLANK_GLYPH;
            active[i] <= BLANK_GLYPH;
         end
      end else begin
         if (copy)
            pending <= 1'b0;
         else if (commit)
            pending <= 1'b1;
         wr_ready   <= copy || (!pending && !commit);
         digit      <= digit_d;
         abcdefgh   <= seg_d;
         frame_done <= wrap;
         for (int i = 0; i < W_DIGIT; i++) begin
            active[i] <= active_n[i];
            if (wr_fire && (wr_idx == 3'(i)))
               shadow[i] <= {wr_dp, wr_char};
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - randomized bench for seg7_scan_ctrl against a frame-level model
module tb_seg7_scan_ctrl;

   localparam int W     = 8;
   localparam int D     = 4;
   localparam int B     = 2;
   localparam int SLOT  = D + B;
   localparam int FRAME = W * SLOT;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [2:0]   wr_idx = '0;
   logic [4:0]   wr_char = '0;
   logic         wr_dp = 1'b0;
   logic         commit = 1'b0;
   logic [W-1:0] digit_en = '1;
   logic [7:0]   abcdefgh;
   logic [W-1:0] digit;
   logic         frame_done;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.W_DIGIT(W), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
      .wr_char(wr_char), .wr_dp(wr_dp), .commit(commit), .digit_en(digit_en),
      .abcdefgh(abcdefgh), .digit(digit), .frame_done(frame_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: cycle t counts from the last reset edge; a frame is FRAME cycles of fixed slots.
   int           t = 0;
   logic [5:0]   sh_m  [W];
   logic [5:0]   act_m [W];
   bit           pend_m = 1'b0;
   bit           en_m   = 1'b0;
   logic [W-1:0] exp_digit = '0;
   logic [7:0]   exp_seg   = '0;
   logic         exp_fd    = 1'b0;
   logic         exp_ready = 1'b1;
   logic [7:0]   enc_tab [32] = '{0:8'hFC, 1:8'h60, 2:8'hDA, 3:8'hF2, 4:8'h66, 5:8'hB6,
                                  6:8'hBE, 7:8'hE0, 8:8'hFE, 9:8'hF6, 10:8'hEE, 11:8'h3E,
                                  12:8'h9C, 13:8'h7A, 14:8'h9E, 15:8'h8E, 16:8'hB6,
                                  17:8'h1C, 18:8'h02, default:8'h00};

   function automatic logic [7:0] model_seg(input logic [5:0] g);
      return enc_tab[g[4:0]] | {7'b0, g[5]};
   endfunction

   task automatic tick();
      bit rdy;
      int pos, slot;
      bit on, boundary;
      @(posedge clk);
      if (rst) begin
         t = 0; pend_m = 1'b0; en_m = 1'b0;
         for (int i = 0; i < W; i++) begin sh_m[i] = 6'h13; act_m[i] = 6'h13; end
         exp_digit = '0; exp_seg = '0; exp_fd = 1'b0; exp_ready = 1'b1;
      end else begin
         rdy = !pend_m;
         t++;
         boundary = (t % FRAME == 0);
         if (boundary && pend_m) begin
            act_m  = sh_m;
            pend_m = 1'b0;
         end else if (commit) begin
            pend_m = 1'b1;
         end
         if (wr_valid && rdy && int'(wr_idx) < W) sh_m[wr_idx] = {wr_dp, wr_char};
         pos  = t % FRAME;
         slot = pos / SLOT;
         on   = (pos % SLOT) >= B;
         if (pos % SLOT == B) en_m = digit_en[slot];
         exp_digit = (on && en_m) ? (W'(1) << slot) : '0;
         exp_seg   = on ? model_seg(act_m[slot]) : 8'h00;
         exp_fd    = boundary;
         exp_ready = !pend_m;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      digit_en = '1;
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'($urandom); commit = 1'($urandom);
         wr_idx = 3'($urandom); wr_char = 5'($urandom); wr_dp = 1'($urandom);
         tick();
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs i=%0d got digit=%h seg=%h fd=%b rdy=%b want 00 00 0 1",
                     i, digit, abcdefgh, frame_done, wr_ready);
         end
      end
      wr_valid = 1'b0; commit = 1'b0; rst = 1'b0;
   endtask

   task automatic test_idle_scan();
      int fd_cnt = 0, fd_sum = 0;
      for (int i = 0; i < 200 && t < 100; i++) begin
         tick();
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_digit, exp_seg, exp_fd, exp_ready}) begin
            n_fail++;
            $display("FAIL idle_scan t=%0d got %h %h %b %b want %h %h %b %b", t, digit, abcdefgh,
                     frame_done, wr_ready, exp_digit, exp_seg, exp_fd, exp_ready);
         end
         if ((t >= 2 && t <= 5) || (t >= 8 && t <= 11)) begin
            n_tests++;
            if (digit !== ((t <= 5) ? 8'h01 : 8'h02)) begin
               n_fail++;
               $display("FAIL idle_digit t=%0d got %h", t, digit);
            end
         end
         if (frame_done) begin fd_cnt++; fd_sum += t; end
      end
      n_tests++;
      if (fd_cnt != 2 || fd_sum != 144) begin
         n_fail++;
         $display("FAIL idle_frame_done got count=%0d sum=%0d want 2 144", fd_cnt, fd_sum);
      end
   endtask

   task automatic test_commit();
      bit seen = 1'b0;
      wr_valid = 1'b1; wr_idx = 3'd0; wr_char = 5'd3; wr_dp = 1'b1;
      tick();
      wr_idx = 3'd2; wr_char = 5'd17; wr_dp = 1'b0;
      tick();
      wr_valid = 1'b0; commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int i = 0; i < 2 * FRAME && !seen; i++) begin
         tick();
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_digit, exp_seg, exp_fd, exp_ready}) begin
            n_fail++;
            $display("FAIL commit_wait t=%0d got %h %h %b %b want %h %h %b %b", t, digit, abcdefgh,
                     frame_done, wr_ready, exp_digit, exp_seg, exp_fd, exp_ready);
         end
         if (frame_done) seen = 1'b1;
         else begin
            n_tests++;
            if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL commit_ready_low t=%0d got %b want 0", t, wr_ready); end
         end
      end
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL commit_boundary_timeout got no frame_done want one"); end
      for (int i = 0; i < FRAME; i++) begin
         tick();
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_digit, exp_seg, exp_fd, exp_ready}) begin
            n_fail++;
            $display("FAIL commit_show t=%0d got %h %h %b %b want %h %h %b %b", t, digit, abcdefgh,
                     frame_done, wr_ready, exp_digit, exp_seg, exp_fd, exp_ready);
         end
         if (t % FRAME == 2 || t % FRAME == 14) begin
            n_tests++;
            if ({digit, abcdefgh} !== ((t % FRAME == 2) ? 16'h01F3 : 16'h041C)) begin
               n_fail++;
               $display("FAIL commit_glyph pos=%0d got digit=%h seg=%h", t % FRAME, digit, abcdefgh);
            end
         end
      end
   endtask

   task automatic test_no_commit();
      bit seen = 1'b0;
      wr_valid = 1'b1; wr_idx = 3'd1; wr_char = 5'd5; wr_dp = 1'b0;
      tick();
      wr_valid = 1'b0;
      for (int i = 0; i < 3 * FRAME + 2 * FRAME; i++) begin
         if (i == 3 * FRAME) commit = 1'b1;
         tick();
         commit = 1'b0;
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_digit, exp_seg, exp_fd, exp_ready}) begin
            n_fail++;
            $display("FAIL no_commit t=%0d got %h %h %b %b want %h %h %b %b", t, digit, abcdefgh,
                     frame_done, wr_ready, exp_digit, exp_seg, exp_fd, exp_ready);
         end
         if (i > 3 * FRAME && frame_done) seen = 1'b1;
         if (t % FRAME == 8) begin
            n_tests++;
            if ({digit, abcdefgh} !== (seen ? 16'h02B6 : 16'h0200)) begin
               n_fail++;
               $display("FAIL no_commit_slot1 i=%0d got digit=%h seg=%h committed=%b", i, digit, abcdefgh, seen);
            end
         end
      end
   endtask

   task automatic test_hold_pending();
      bit accepted = 1'b0, rdy;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      wr_valid = 1'b1; wr_idx = 3'd3; wr_char = 5'd16; wr_dp = 1'b0;
      for (int i = 0; i < 3 * FRAME + 8; i++) begin
         rdy = exp_ready;
         if (i == 2 * FRAME + 4) commit = 1'b1;
         tick();
         commit = 1'b0;
         if (rdy && wr_valid) begin accepted = 1'b1; wr_valid = 1'b0; end
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_digit, exp_seg, exp_fd, exp_ready}) begin
            n_fail++;
            $display("FAIL hold_pending t=%0d got %h %h %b %b want %h %h %b %b", t, digit, abcdefgh,
                     frame_done, wr_ready, exp_digit, exp_seg, exp_fd, exp_ready);
         end
         if (t % FRAME == 20 && i < 2 * FRAME) begin
            n_tests++;
            if (abcdefgh !== 8'h00) begin n_fail++; $display("FAIL hold_not_active t=%0d got %h want 00", t, abcdefgh); end
         end
      end
      wr_valid = 1'b0;
      n_tests++;
      if (!accepted) begin n_fail++; $display("FAIL hold_accept_timeout got never ready want accept"); end
   endtask

   task automatic test_digit_en();
      int p;
      digit_en = 8'hFE;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_digit, exp_seg, exp_fd, exp_ready}) begin
            n_fail++;
            $display("FAIL digit_en t=%0d got %h %h %b %b want %h %h %b %b", t, digit, abcdefgh,
                     frame_done, wr_ready, exp_digit, exp_seg, exp_fd, exp_ready);
         end
         p = t % FRAME;
         if (i >= FRAME && ((p >= 2 && p <= 5) || (p >= 8 && p <= 11))) begin
            n_tests++;
            if (digit !== ((p <= 5) ? 8'h00 : 8'h02)) begin
               n_fail++;
               $display("FAIL digit_en_slot pos=%0d got %h", p, digit);
            end
         end
      end
      digit_en = '1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         digit_en = W'($urandom);
         wr_valid = ($urandom_range(0, 2) == 0);
         wr_idx = 3'($urandom); wr_char = 5'($urandom); wr_dp = 1'($urandom);
         commit = ($urandom_range(0, 15) == 0);
         tick();
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_digit, exp_seg, exp_fd, exp_ready}) begin
            n_fail++;
            $display("FAIL random t=%0d got %h %h %b %b want %h %h %b %b", t, digit, abcdefgh,
                     frame_done, wr_ready, exp_digit, exp_seg, exp_fd, exp_ready);
         end
      end
      wr_valid = 1'b0; commit = 1'b0; digit_en = '1;
   endtask

   task automatic test_reset_mid();
      bit phase2 = 1'b0, hit = 1'b0;
      for (int i = 0; i < 4 * FRAME && !hit; i++) begin
         if (!phase2 && t % FRAME == 1) begin
            wr_valid = 1'b1; wr_idx = 3'd5; wr_char = 5'd8; wr_dp = 1'b1; commit = 1'b1;
            phase2 = 1'b1;
         end
         tick();
         wr_valid = 1'b0; commit = 1'b0;
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_digit, exp_seg, exp_fd, exp_ready}) begin
            n_fail++;
            $display("FAIL reset_mid_pre t=%0d got %h %h %b %b want %h %h %b %b", t, digit, abcdefgh,
                     frame_done, wr_ready, exp_digit, exp_seg, exp_fd, exp_ready);
         end
         if (phase2 && t % FRAME == 5 * SLOT + B + 1) hit = 1'b1;
      end
      n_tests++;
      if (!hit || wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_setup got reached=%b rdy=%b want 1 0", hit, wr_ready);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({digit, abcdefgh, frame_done, wr_ready} !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_outputs got %h %h %b %b want 00 00 0 1", digit, abcdefgh, frame_done, wr_ready);
      end
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         n_tests++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_digit, exp_seg, exp_fd, exp_ready}) begin
            n_fail++;
            $display("FAIL reset_mid_scan t=%0d got %h %h %b %b want %h %h %b %b", t, digit, abcdefgh,
                     frame_done, wr_ready, exp_digit, exp_seg, exp_fd, exp_ready);
         end
         n_tests++;
         if (abcdefgh !== 8'h00 || (t == 2 && digit !== 8'h01)) begin
            n_fail++;
            $display("FAIL reset_mid_blank t=%0d got digit=%h seg=%h want blank glyphs", t, digit, abcdefgh);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_commit();
      test_no_commit();
      test_hold_pending();
      test_digit_en();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no completion want finish");
      $fatal(1);
   end

endmodule
